// File: rtl/uart_rx_device_pkg.sv
// Shared definitions for the UART receive device: MMIO addresses, FSM state types,
// status bit positions and the count saturation helper.
package uart_rx_device_pkg;

  localparam logic [63:0] RX_DATA_ADDR = 64'h0000_0000_1000_0010;
  localparam logic [63:0] RX_STAT_ADDR = 64'h0000_0000_1000_0018;

  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERRUN   = 2;
  localparam int STAT_FRAME_ERR = 3;
  localparam int STAT_COUNT_LSB = 4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  typedef enum logic [1:0] {B_IDLE, B_RESP, B_WAIT} bus_state_t;

  // The status register only has four bits for the count, so deeper FIFOs report 15.
  function automatic logic [3:0] satCount(input logic [31:0] n);
    return (n > 32'd15) ? 4'hF : n[3:0];
  endfunction

endpackage

// File: rtl/uart_rx_device_if.sv
// CPU MMIO request/response bundle shared by the bus master and this device.
interface uart_rx_device_if;
  logic        valid;
  logic [63:0] addr;
  logic        wvalid;
  logic [7:0]  size;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic        ready;
  logic        hit;

  modport master (output valid, addr, wvalid, size, wdata, input rdata, ready, hit);
  modport slave  (input valid, addr, wvalid, size, wdata, output rdata, ready, hit);
endinterface

// File: rtl/uart_rx_device_fifo.sv
// Small byte FIFO for received characters; head byte is visible combinationally.
module uart_rx_device_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [7:0]               i_data,
  output logic [7:0]               o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic          w_doPush;
  logic          w_doPop;

  assign o_full   = (r_count == CW'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;
  assign o_head   = r_mem[r_rdPtr];
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_doPop  = i_pop && !o_empty;
  assign w_doPush = i_push && (!o_full || w_doPop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_data;
  end

endmodule

// File: rtl/uart_rx_device.sv
// UART 8N1 receiver on the CPU MMIO bus: synchroniser, bit timer, receive FSM,
// receive FIFO and a data/status register pair with sticky error flags.
module uart_rx_device
  import uart_rx_device_pkg::*;
#(
  parameter logic [13:0] BIT_TMR_MAX = 14'd10416,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  uart_rx_device_if.slave  bus
);

  localparam logic [13:0] HALF = BIT_TMR_MAX >> 1;
  localparam int          CW   = $clog2(FIFO_DEPTH) + 1;

  logic        r_rxSync1, r_rxSync2;
  rx_state_t   r_rxState, w_rxStateNext;
  logic [13:0] r_bitTmr, w_bitTmrNext;
  logic [2:0]  r_bitCnt, w_bitCntNext;
  logic [7:0]  r_shift, w_shiftNext;
  logic        w_pushReq, w_frameErrSet;

  bus_state_t  r_busState, w_busStateNext;
  logic [63:0] r_rdata, w_rdataNext;
  logic        w_pop, w_overrunClr, w_frameErrClr, w_overrunSet;
  logic        r_overrun, r_frameErr;
  logic        w_hit, w_isData, w_isStat;

  logic [7:0]    w_head;
  logic          w_full, w_empty;
  logic [CW-1:0] w_count;
  logic [63:0]   w_status;
  logic          w_unused;

  assign w_unused = ^{bus.size, bus.wdata[63:4], bus.wdata[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rxSync1 <= 1'b1;
      r_rxSync2 <= 1'b1;
    end else begin
      r_rxSync1 <= rx;
      r_rxSync2 <= r_rxSync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rxState <= IDLE;
      r_bitTmr  <= '0;
      r_bitCnt  <= '0;
      r_shift   <= '0;
    end else begin
      r_rxState <= w_rxStateNext;
      r_bitTmr  <= w_bitTmrNext;
      r_bitCnt  <= w_bitCntNext;
      r_shift   <= w_shiftNext;
    end
  end

  // Start bit is re-checked at mid-bit; data and stop bits are then sampled a full bit apart.
  always_comb begin
    w_rxStateNext = r_rxState;
    w_bitTmrNext  = r_bitTmr + 14'd1;
    w_bitCntNext  = r_bitCnt;
    w_shiftNext   = r_shift;
    w_pushReq     = 1'b0;
    w_frameErrSet = 1'b0;
    case (r_rxState)
      IDLE: begin
        w_bitTmrNext = '0;
        if (!r_rxSync2) w_rxStateNext = START;
      end
      START: if (r_bitTmr == HALF) begin
        w_bitTmrNext = '0;
        w_bitCntNext = '0;
        w_rxStateNext = r_rxSync2 ? IDLE : DATA;
      end
      DATA: if (r_bitTmr == BIT_TMR_MAX) begin
        w_bitTmrNext = '0;
        w_shiftNext  = {r_rxSync2, r_shift[7:1]};
        w_bitCntNext = r_bitCnt + 3'd1;
        if (r_bitCnt == 3'd7) w_rxStateNext = STOP;
      end
      STOP: if (r_bitTmr == BIT_TMR_MAX) begin
        w_bitTmrNext  = '0;
        w_pushReq     = r_rxSync2;
        w_frameErrSet = !r_rxSync2;
        w_rxStateNext = IDLE;
      end
      default: w_rxStateNext = IDLE;
    endcase
  end

  uart_rx_device_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_pushReq),
    .i_pop   (w_pop),
    .i_data  (r_shift),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_overrunSet = w_pushReq && w_full && !w_pop;
  assign w_isData     = (bus.addr == RX_DATA_ADDR);
  assign w_isStat     = (bus.addr == RX_STAT_ADDR);
  assign w_hit        = bus.valid && (w_isData || w_isStat);
  assign bus.hit      = w_hit;
  assign bus.ready    = (r_busState == B_RESP);
  assign bus.rdata    = r_rdata;

  always_comb begin
    w_status = '0;
    w_status[STAT_NOT_EMPTY] = !w_empty;
    w_status[STAT_FULL]      = w_full;
    w_status[STAT_OVERRUN]   = r_overrun;
    w_status[STAT_FRAME_ERR] = r_frameErr;
    w_status[STAT_COUNT_LSB +: 4] = satCount(32'(w_count));
  end

  // Each request is served once in B_IDLE; B_WAIT holds off until valid drops so a long
  // request cannot pop twice.
  always_comb begin
    w_busStateNext = r_busState;
    w_rdataNext    = r_rdata;
    w_pop          = 1'b0;
    w_overrunClr   = 1'b0;
    w_frameErrClr  = 1'b0;
    case (r_busState)
      B_IDLE: if (w_hit) begin
        w_busStateNext = B_RESP;
        if (bus.wvalid) begin
          w_rdataNext   = '0;
          w_overrunClr  = w_isStat && bus.wdata[STAT_OVERRUN];
          w_frameErrClr = w_isStat && bus.wdata[STAT_FRAME_ERR];
        end else if (w_isData) begin
          w_rdataNext = w_empty ? 64'd0 : {56'd0, w_head};
          w_pop       = !w_empty;
        end else begin
          w_rdataNext = w_status;
        end
      end
      B_RESP: w_busStateNext = B_WAIT;
      B_WAIT: if (!bus.valid) w_busStateNext = B_IDLE;
      default: w_busStateNext = B_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busState <= B_IDLE;
      r_rdata    <= '0;
      r_overrun  <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      r_busState <= w_busStateNext;
      r_rdata    <= w_rdataNext;
      if (w_overrunSet)       r_overrun <= 1'b1;
      else if (w_overrunClr)  r_overrun <= 1'b0;
      if (w_frameErrSet)      r_frameErr <= 1'b1;
      else if (w_frameErrClr) r_frameErr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_device.sv
// Scoreboard bench for uart_rx_device: bus requests queue their expected rdata and a
// monitor compares on every ready pulse.
module tb_uart_rx_device;
  import uart_rx_device_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic rx    = 1'b1;

  uart_rx_device_if bus();

  uart_rx_device #(.BIT_TMR_MAX(14'd15), .FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        check;
    logic [63:0] data;
  } exp_t;

  exp_t expQ[$];
  exp_t monItem;
  int   checks = 0;
  int   errors = 0;
  int   readyPulses = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every ready pulse consumes one queued expectation.
  always @(negedge clk) begin
    if (bus.ready === 1'b1) begin
      readyPulses++;
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_ready: got ready with rdata 0x%0h, expected no response", bus.rdata);
      end else begin
        monItem = expQ.pop_front();
        if (monItem.check) checkOutput(monItem.name, bus.rdata, monItem.data);
      end
    end
  end

  // Must be called right after a negedge; valid stays high at least 'hold' cycles.
  task automatic applyStimulus(input string name, input logic [63:0] addr, input logic wr,
                               input logic [63:0] wdata, input logic check,
                               input logic [63:0] expected, input int hold);
    int  cycles;
    bit  got;
    expQ.push_back('{name, check, expected});
    bus.addr   = addr;
    bus.wvalid = wr;
    bus.wdata  = wdata;
    bus.valid  = 1'b1;
    cycles = 0;
    got    = 1'b0;
    while (1) begin
      @(negedge clk);
      cycles++;
      if (bus.ready === 1'b1) got = 1'b1;
      if ((got && cycles >= hold) || cycles >= hold + 40) break;
    end
    bus.valid  = 1'b0;
    bus.wvalid = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: got no ready in %0d cycles, expected a ready pulse", name, cycles);
      expQ.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic readStat(input string name, input logic [63:0] expected);
    applyStimulus(name, RX_STAT_ADDR, 1'b0, 64'd0, 1'b1, expected, 1);
  endtask

  task automatic readData(input string name, input logic [63:0] expected);
    applyStimulus(name, RX_DATA_ADDR, 1'b0, 64'd0, 1'b1, expected, 1);
  endtask

  task automatic writeStat(input string name, input logic [63:0] wdata);
    applyStimulus(name, RX_STAT_ADDR, 1'b1, wdata, 1'b0, 64'd0, 1);
  endtask

  // 16 clocks per bit, LSB first; called at a negedge.
  task automatic sendFrame(input logic [7:0] d, input logic stopBit);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (16) @(negedge clk);
    end
    rx = stopBit;
    repeat (16) @(negedge clk);
    rx = 1'b1;
  endtask

  initial begin
    int p0;
    bus.valid  = 1'b0;
    bus.addr   = 64'd0;
    bus.wvalid = 1'b0;
    bus.size   = 8'd8;
    bus.wdata  = 64'd0;

    repeat (3) @(negedge clk);
    checkOutput("reset_ready", 64'(bus.ready), 64'd0);
    checkOutput("reset_rdata", bus.rdata, 64'd0);
    checkOutput("reset_rx_state", 64'(dut.r_rxState), 64'(IDLE));
    reset = 1'b0;
    repeat (2) @(negedge clk);
    readStat("reset_stat", 64'h00);

    $display("[TB] frame 0x55");
    sendFrame(8'h55, 1'b1);
    readStat("t1_stat", 64'h11);
    readData("t1_data", 64'h55);
    readStat("t1_stat_after", 64'h00);

    $display("[TB] short glitch");
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("t2_rx_state", 64'(dut.r_rxState), 64'(IDLE));
    readStat("t2_stat", 64'h00);

    $display("[TB] framing error");
    sendFrame(8'hA3, 1'b0);
    repeat (20) @(negedge clk);
    readStat("t3_stat", 64'h08);
    writeStat("t3_clear", 64'h8);
    readStat("t3_stat_cleared", 64'h00);

    $display("[TB] overrun");
    for (int i = 1; i <= 5; i++) sendFrame(8'(i), 1'b1);
    readStat("t4_stat", 64'h47);
    readData("t4_data1", 64'h01);
    readData("t4_data2", 64'h02);
    readData("t4_data3", 64'h03);
    readData("t4_data4", 64'h04);
    readData("t4_empty", 64'h00);
    writeStat("t4_clear", 64'h4);
    readStat("t4_stat_cleared", 64'h00);

    $display("[TB] pop and push on the same edge while full");
    sendFrame(8'h11, 1'b1);
    sendFrame(8'h22, 1'b1);
    sendFrame(8'h33, 1'b1);
    sendFrame(8'h44, 1'b1);
    readStat("t5_stat_full", 64'h43);
    fork
      sendFrame(8'h99, 1'b1);
      begin
        repeat (153) @(negedge clk);
        readData("t5_pop_at_push", 64'h11);
      end
    join
    readStat("t5_stat_no_overrun", 64'h43);
    readData("t5_data2", 64'h22);
    readData("t5_data3", 64'h33);
    readData("t5_data4", 64'h44);
    readData("t5_data_last", 64'h99);
    readStat("t5_stat_empty", 64'h00);

    $display("[TB] long request and reset mid-frame");
    sendFrame(8'hC1, 1'b1);
    sendFrame(8'hC2, 1'b1);
    readStat("t6_stat_two", 64'h21);
    p0 = readyPulses;
    applyStimulus("t6_hold_data", RX_DATA_ADDR, 1'b0, 64'd0, 1'b1, 64'hC1, 10);
    checkOutput("t6_ready_pulses", 64'(readyPulses - p0), 64'd1);
    readStat("t6_stat_one", 64'h11);
    fork
      sendFrame(8'h0F, 1'b1);
      begin
        repeat (40) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("t6_reset_ready", 64'(bus.ready), 64'd0);
        checkOutput("t6_reset_rx_state", 64'(dut.r_rxState), 64'(IDLE));
        reset = 1'b0;
        @(negedge clk);
        readStat("t6_stat_after_reset", 64'h00);
      end
    join
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
